// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: divide FSM states,
// E-stage bypass select codes and the register-match helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // $zero is hard-wired, so a write to it never produces a dependency
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_unit_div_seq.sv
// Divide sequencer: launches the iterative divider in E, counts its
// iterations and holds the result-valid state until the pipeline can take it.
module div_seq
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_divE,
    input  logic i_exceptM,
    input  logic i_longest_stall,
    output logic o_divstall,
    output logic o_div_start,
    output logic o_div_ready
);

    localparam int unsigned CW = $clog2(DIV_CYCLES);

    div_state_e    r_state;
    div_state_e    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A frozen pipeline blocks launch and retirement, but the divider itself
    // keeps iterating, so BUSY counts through a long stall.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        o_div_start  = 1'b0;
        o_div_ready  = 1'b0;
        w_abort      = i_exceptM && !i_longest_stall;
        case (r_state)
            IDLE: begin
                if (i_divE && !i_longest_stall && !i_exceptM) begin
                    o_div_start  = 1'b1;
                    w_cnt_next   = CW'(DIV_CYCLES - 1);
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == '0) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            DONE: begin
                o_div_ready = 1'b1;
                if (w_abort) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (!i_longest_stall) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_divstall = i_divE && (r_state != DONE);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard and stall sequencer for the 5-stage MIPS core: bypass
// selects, load-use / branch / divide stalls, exception flushes.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       jgetregD,
    input  logic       divE,
    input  logic       i_busy,
    input  logic       d_busy,
    input  logic       exceptM,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW,
    output logic       longest_stall,
    output logic       div_start,
    output logic       div_ready
);

    logic w_ls;
    logic w_lwstall;
    logic w_brstall;
    logic w_divstall;
    logic w_div_start;
    logic w_div_ready;
    logic w_srcD_in_E;
    logic w_srcD_in_M;

    assign w_ls        = i_busy || d_busy;
    assign w_srcD_in_E = (writeregE == rsD) || (writeregE == rtD);
    assign w_srcD_in_M = (writeregM == rsD) || (writeregM == rtD);
    assign w_lwstall   = memtoregE && reg_hit(writeregE, rsD | 5'd0)
                       || memtoregE && reg_hit(writeregE, rtD);
    assign w_brstall   = (branchD || jgetregD)
                       && ((regwriteE && w_srcD_in_E) || (memtoregM && w_srcD_in_M));

    div_seq #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div_seq (
        .clk            (clk),
        .rst            (rst),
        .i_divE         (divE),
        .i_exceptM      (exceptM),
        .i_longest_stall(w_ls),
        .o_divstall     (w_divstall),
        .o_div_start    (w_div_start),
        .o_div_ready    (w_div_ready)
    );

    always_comb begin
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        if (!rst) begin
            if (regwriteM && reg_hit(writeregM, rsE)) begin
                forwardAE = FWD_M;
            end else if (regwriteW && reg_hit(writeregW, rsE)) begin
                forwardAE = FWD_W;
            end
            if (regwriteM && reg_hit(writeregM, rtE)) begin
                forwardBE = FWD_M;
            end else if (regwriteW && reg_hit(writeregW, rtE)) begin
                forwardBE = FWD_W;
            end
            forwardAD = regwriteM && reg_hit(writeregM, rsD);
            forwardBD = regwriteM && reg_hit(writeregM, rtD);
        end
    end

    // An exception waiting behind a memory stall is deferred, not lost:
    // M is frozen, so exceptM is presented again once the stall clears.
    always_comb begin
        stallF        = 1'b0;
        stallD        = 1'b0;
        stallE        = 1'b0;
        flushD        = 1'b0;
        flushE        = 1'b0;
        flushM        = 1'b0;
        flushW        = 1'b0;
        longest_stall = 1'b0;
        div_start     = 1'b0;
        div_ready     = 1'b0;
        if (!rst) begin
            longest_stall = w_ls;
            div_start     = w_div_start;
            div_ready     = w_div_ready;
            if (exceptM && !w_ls) begin
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
                flushW = 1'b1;
            end else if (w_ls) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
            end else if (w_divstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (w_lwstall || w_brstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: fixed vectors, divide corner
// sequences, then random stimulus against a cycle-age reference model.
module tb_hazard_unit;

    localparam int unsigned DIVC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, jgetregD, divE, i_busy, d_busy, exceptM;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, stallE, flushD, flushE, flushM, flushW;
    logic       longest_stall, div_start, div_ready;

    int checks = 0;
    int errors = 0;

    // divider model: idle, or number of cycles since the launch cycle
    bit m_active;
    int m_age;

    always #5 clk = ~clk;

    hazard_unit #(.DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jgetregD(jgetregD), .divE(divE),
        .i_busy(i_busy), .d_busy(d_busy), .exceptM(exceptM),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .longest_stall(longest_stall), .div_start(div_start), .div_ready(div_ready)
    );

    typedef struct {
        logic [4:0]  rsD, rtD, rsE, rtE, wE, wM, wW;
        logic [9:0]  ctl;   // {rwE,rwM,rwW,mtrE,mtrM,br,jr,ib,db,exc}
        logic [15:0] exp;   // {fwdAD,fwdBD,fwdAE,fwdBE,stFDE,flDEMW,ls,dstart,dready}
    } vec_t;

    vec_t vecs[13];

    function automatic logic [15:0] dut_out();
        return {forwardAD, forwardBD, forwardAE, forwardBE, stallF, stallD, stallE,
                flushD, flushE, flushM, flushW, longest_stall, div_start, div_ready};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] divexp(input logic [2:0] st, input logic [3:0] fl,
                                           input logic ls, input logic ds, input logic dr);
        return {6'b0, st, fl, ls, ds, dr};
    endfunction

    task automatic clear_inputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
        {branchD, jgetregD, divE, i_busy, d_busy, exceptM} = '0;
    endtask

    task automatic reset_cycle();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [1:0] fwd_e(input logic [4:0] src);
        if (regwriteM && writeregM != 0 && writeregM == src) return 2'b10;
        if (regwriteW && writeregW != 0 && writeregW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [15:0] model_out();
        logic ls, lw, br, ready, dstall, dstart;
        logic [2:0] st;
        logic [3:0] fl;
        if (rst) return 16'h0;
        ls     = i_busy | d_busy;
        lw     = memtoregE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
        br     = (branchD || jgetregD) &&
                 ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                  (memtoregM && (writeregM == rsD || writeregM == rtD)));
        ready  = m_active && (m_age == DIVC + 1);
        dstall = divE && !ready;
        dstart = !m_active && divE && !ls && !exceptM;
        st = 3'b000;
        fl = 4'b0000;
        if (exceptM && !ls) fl = 4'b1111;
        else if (ls) st = 3'b111;
        else if (dstall) begin st = 3'b111; fl = 4'b0010; end
        else if (lw || br) begin st = 3'b110; fl = 4'b0100; end
        return {regwriteM && writeregM != 0 && writeregM == rsD,
                regwriteM && writeregM != 0 && writeregM == rtD,
                fwd_e(rsE), fwd_e(rtE), st, fl, ls, dstart, ready};
    endfunction

    task automatic model_advance();
        logic ls, abort;
        ls    = i_busy | d_busy;
        abort = exceptM && !ls;
        if (rst) begin
            m_active = 0;
            m_age    = 0;
        end else if (!m_active) begin
            if (divE && !ls && !exceptM) begin
                m_active = 1;
                m_age    = 1;
            end
        end else if (m_age <= DIVC) begin
            if (abort) m_active = 0;
            else m_age++;
        end else begin
            if (abort || !ls) m_active = 0;
        end
    endtask

    initial begin
        vecs[0]  = '{5'd1, 5'd2, 5'd5, 5'd3, 5'd9, 5'd5, 5'd5, 10'b0110000000, {2'b00, 4'b1000, 3'b000, 4'b0000, 3'b000}};
        vecs[1]  = '{5'd1, 5'd2, 5'd5, 5'd3, 5'd9, 5'd0, 5'd5, 10'b0110000000, {2'b00, 4'b0100, 3'b000, 4'b0000, 3'b000}};
        vecs[2]  = '{5'd7, 5'd3, 5'd7, 5'd7, 5'd0, 5'd7, 5'd7, 10'b0100000000, {2'b10, 4'b1010, 3'b000, 4'b0000, 3'b000}};
        vecs[3]  = '{5'd4, 5'd0, 5'd4, 5'd4, 5'd0, 5'd4, 5'd4, 10'b0010000000, {2'b00, 4'b0101, 3'b000, 4'b0000, 3'b000}};
        vecs[4]  = '{5'd1, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 10'b1001000000, {2'b00, 4'b0000, 3'b110, 4'b0100, 3'b000}};
        vecs[5]  = '{5'd0, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 10'b1001000000, {2'b00, 4'b0000, 3'b000, 4'b0000, 3'b000}};
        vecs[6]  = '{5'd3, 5'd1, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 10'b1000010000, {2'b00, 4'b0000, 3'b110, 4'b0100, 3'b000}};
        vecs[7]  = '{5'd1, 5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 10'b0100101000, {2'b01, 4'b0000, 3'b110, 4'b0100, 3'b000}};
        vecs[8]  = '{5'd4, 5'd5, 5'd0, 5'd0, 5'd3, 5'd7, 5'd0, 10'b1000110000, {2'b00, 4'b0000, 3'b000, 4'b0000, 3'b000}};
        vecs[9]  = '{5'd1, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 10'b1001000001, {2'b00, 4'b0000, 3'b000, 4'b1111, 3'b000}};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 10'b0000000101, {2'b00, 4'b0000, 3'b111, 4'b0000, 3'b100}};
        vecs[11] = '{5'd1, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 10'b1001000010, {2'b00, 4'b0000, 3'b111, 4'b0000, 3'b100}};
        vecs[12] = '{5'd3, 5'd1, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 10'b0000010000, {2'b00, 4'b0000, 3'b000, 4'b0000, 3'b000}};

        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        // reset dominates even with live hazards on the inputs
        rsE = 5'd5; writeregM = 5'd5; regwriteM = 1'b1; divE = 1'b1;
        exceptM = 1'b1; i_busy = 1'b1; memtoregE = 1'b1; writeregE = 5'd5; rsD = 5'd5;
        #1 check("reset", dut_out(), 16'h0);
        @(negedge clk);
        reset_cycle();

        for (int i = 0; i < 13; i++) begin
            {rsD, rtD, rsE, rtE} = {vecs[i].rsD, vecs[i].rtD, vecs[i].rsE, vecs[i].rtE};
            {writeregE, writeregM, writeregW} = {vecs[i].wE, vecs[i].wM, vecs[i].wW};
            {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
             branchD, jgetregD, i_busy, d_busy, exceptM} = vecs[i].ctl;
            divE = 1'b0;
            #1 check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
            @(negedge clk);
        end

        // divide with divE held, then a back-to-back second divide
        reset_cycle();
        divE = 1'b1;
        for (int c = 0; c <= DIVC + 2; c++) begin
            #1;
            if (c <= DIVC)
                check($sformatf("div_c%0d", c), dut_out(), divexp(3'b111, 4'b0010, 1'b0, c == 0, 1'b0));
            else if (c == DIVC + 1)
                check("div_done", dut_out(), divexp(3'b000, 4'b0000, 1'b0, 1'b0, 1'b1));
            else
                check("div_b2b", dut_out(), divexp(3'b111, 4'b0010, 1'b0, 1'b1, 1'b0));
            @(negedge clk);
        end

        // memory stall while DONE keeps div_ready up
        reset_cycle();
        for (int c = 0; c <= DIVC + 5; c++) begin
            divE   = (c <= DIVC + 4);
            d_busy = (c >= DIVC + 1 && c <= DIVC + 3);
            #1;
            if (c <= DIVC)
                check($sformatf("lsd_c%0d", c), dut_out(), divexp(3'b111, 4'b0010, 1'b0, c == 0, 1'b0));
            else if (c <= DIVC + 3)
                check($sformatf("lsd_hold%0d", c), dut_out(), divexp(3'b111, 4'b0000, 1'b1, 1'b0, 1'b1));
            else if (c == DIVC + 4)
                check("lsd_retire", dut_out(), divexp(3'b000, 4'b0000, 1'b0, 1'b0, 1'b1));
            else
                check("lsd_idle", dut_out(), 16'h0);
            @(negedge clk);
        end

        // exception deferred by i_busy, then aborts the divide
        reset_cycle();
        divE = 1'b1;
        #1 check("exc_c0", dut_out(), divexp(3'b111, 4'b0010, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        #1 check("exc_c1", dut_out(), divexp(3'b111, 4'b0010, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        exceptM = 1'b1; i_busy = 1'b1;
        #1 check("exc_held", dut_out(), divexp(3'b111, 4'b0000, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        i_busy = 1'b0;
        #1 check("exc_flush", dut_out(), divexp(3'b000, 4'b1111, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        exceptM = 1'b0;
        #1 check("exc_restart", dut_out(), divexp(3'b111, 4'b0010, 1'b0, 1'b1, 1'b0));
        @(negedge clk);

        // reset in BUSY with cnt = 2
        reset_cycle();
        divE = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst_busy", dut_out(), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_idle", dut_out(), divexp(3'b111, 4'b0010, 1'b0, 1'b1, 1'b0));
        @(negedge clk);

        // random stimulus against the reference model
        m_active = 0;
        m_age    = 0;
        for (int n = 0; n < 3000; n++) begin
            rst       = (n == 0) || ($urandom_range(63) == 0);
            rsD       = 5'($urandom_range(3));
            rtD       = 5'($urandom_range(3));
            rsE       = 5'($urandom_range(3));
            rtE       = 5'($urandom_range(3));
            writeregE = 5'($urandom_range(3));
            writeregM = 5'($urandom_range(3));
            writeregW = 5'($urandom_range(3));
            {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = 5'($urandom);
            branchD   = ($urandom_range(3) == 0);
            jgetregD  = ($urandom_range(7) == 0);
            divE      = ($urandom_range(2) != 0);
            i_busy    = ($urandom_range(7) == 0);
            d_busy    = ($urandom_range(7) == 0);
            exceptM   = ($urandom_range(15) == 0);
            #1 check("rand", dut_out(), model_out());
            model_advance();
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It sits beside the controller and datapath and produces all per-stage stall, flush and bypass-select signals, including the `stallD`, `stallE`, `flushE`, `flushM`, `flushW` and `longest_stall` consumed by the controller's pipeline registers. It also owns the multi-cycle divide sequencer, which holds F/D/E while the iterative divider in E runs.

## Interface
- `DIV_CYCLES`, default 32: divider iteration count (≥2).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `rsD`, `rtD`, `rsE`, `rtE` in 5: source register numbers in D and E.
- `writeregE`, `writeregM`, `writeregW` in 5: destination register numbers.
- `regwriteE`, `regwriteM`, `regwriteW` in 1: register-write enables.
- `memtoregE`, `memtoregM` in 1: load in E / M.
- `branchD`, `jgetregD` in 1: D instruction compares/reads registers in D (branch, jr/jalr).
- `divE` in 1: E holds div/divu.
- `i_busy`, `d_busy` in 1: instruction / data memory access outstanding.
- `exceptM` in 1: exception or eret committing in M.
- `forwardAD`, `forwardBD` out 1: D-stage bypass from M.
- `forwardAE`, `forwardBE` out 2: E-stage bypass select (00 reg file, 01 W, 10 M).
- `stallF`, `stallD`, `stallE` out 1: hold F/D/E registers.
- `flushD`, `flushE`, `flushM`, `flushW` out 1: clear stage registers.
- `longest_stall` out 1: freeze whole pipeline including M/W.
- `div_start` out 1: one-cycle divider launch pulse.
- `div_ready` out 1: divider result valid this cycle.

## Operation
- Forwarding, with register 0 never a match:
  - `forwardAE` = 10 if `regwriteM` and `writeregM == rsE`; else 01 if `regwriteW` and `writeregW == rsE`; else 00. `forwardBE` is the same using `rtE`.
  - `forwardAD`/`forwardBD` = `regwriteM` and `writeregM` equals `rsD`/`rtD`.
- `lwstall` = `memtoregE` and `writeregE` ∈ {`rsD`, `rtD`}, with `writeregE` ≠ 0.
- `brstall` = (`branchD` or `jgetregD`) and either:
  - `regwriteE` and `writeregE` ∈ {`rsD`, `rtD`}, or
  - `memtoregM` and `writeregM` ∈ {`rsD`, `rtD`}.
- Divide FSM, states `IDLE`, `BUSY`, `DONE`:
  - `IDLE`: when `divE`, `div_start` = 1, load `cnt` = `DIV_CYCLES`−1, go to `BUSY`.
  - `BUSY`: `cnt` decrements each cycle; at `cnt` = 0 go to `DONE`.
  - `DONE`: `div_ready` = 1; go to `IDLE` unless `longest_stall`, in which case stay in `DONE`.
  - `divstall` = `divE` and state ≠ `DONE`.
  - `exceptM` in `BUSY` or `DONE` forces `IDLE` and clears `cnt`.
- Output priority, highest first:
  1. `rst`: all outputs 0.
  2. `exceptM` and not `longest_stall`: `flushD`, `flushE`, `flushM`, `flushW` = 1; no stalls.
  3. `longest_stall` = `i_busy` or `d_busy`: `stallF`, `stallD`, `stallE` = 1; all flushes 0. The FSM and `cnt` hold, except the `BUSY` counter keeps counting, since the divider runs independently.
  4. `divstall`: `stallF`, `stallD`, `stallE` = 1; `flushM` = 1 (bubble into M).
  5. `lwstall` or `brstall`: `stallF`, `stallD` = 1; `flushE` = 1.
- Forward selects are always computed, independent of stalls.

## Timing
- Forwarding, hazard detection and stall/flush outputs are combinational from the same-cycle inputs. The only state is the FSM and `cnt`.
- Reset values: state `IDLE`, `cnt` 0, `div_start` 0, `div_ready` 0.
- Divide sequence, with cycle 0 the first cycle `divE` is high in `IDLE`:
  - Cycle 0: `div_start` = 1.
  - Cycles 1..`DIV_CYCLES`: `BUSY`.
  - Cycle `DIV_CYCLES`+1: `DONE`, `div_ready` = 1, `stallE` = 0; E advances at the end of this cycle.
  - `stallE` is high on cycles 0..`DIV_CYCLES`, i.e. `DIV_CYCLES`+1 stall cycles.
- A div in E immediately after `DONE` retires starts a fresh sequence the next cycle with no idle gap.
- `rst` asserted mid-divide returns the FSM to `IDLE` at the next edge; no `div_ready` is emitted.
- `exceptM` while `longest_stall` = 1 produces no flush. The flush is issued in the first cycle `longest_stall` is low, which relies on M being frozen so `exceptM` is still presented.
- Simultaneous `lwstall` and `divstall`: `divstall` wins (`flushM`, not `flushE`).

## Structure
- Shared package `hazard_pkg`:
  - FSM state encoding (`IDLE` = 2'd0, `BUSY` = 2'd1, `DONE` = 2'd2).
  - `FWD_RF` = 2'b00, `FWD_W` = 2'b01, `FWD_M` = 2'b10.
- One sub-module, `div_seq`: the FSM plus the `$clog2(DIV_CYCLES)`-bit counter. It outputs `divstall`, `div_start` and `div_ready`.

## Test plan
- Forwarding: `regwriteM` = 1, `writeregM` = `rsE` = 5 and `regwriteW` = 1, `writeregW` = 5 → `forwardAE` = 10. With `writeregM` = 0 instead → `forwardAE` = 01.
- Load-use: `memtoregE` = 1, `writeregE` = `rtD` = 8 → `stallF` = `stallD` = `flushE` = 1 for exactly that cycle; with `writeregE` = 0 → no stall.
- Divide: `DIV_CYCLES` = 4, `divE` held → `div_start` pulse on cycle 0, `stallE` = 1 on cycles 0–4, `div_ready` = 1 on cycle 5, `flushM` = 1 on cycles 0–4.
- `longest_stall` during `DONE`: `d_busy` = 1 for 3 cycles → FSM stays `DONE` and `div_ready` stays high 4 cycles; all flushes 0.
- Exception: `exceptM` = 1 while `i_busy` = 1 → no flush. When `i_busy` drops → `flushD`, `flushE`, `flushM`, `flushW` = 1 that cycle, and the FSM aborts to `IDLE` if busy.
- Reset mid-divide in `BUSY` at `cnt` = 2 → next cycle state `IDLE`, all outputs 0 while `rst` is high.
